// File: rtl/k12_pkg.sv
// -----------------------------------------------------------------------------
// k12_pkg
// Shared definitions for the K12 PoW core array and its result collector:
// nonce width and type, drop-counter width and a saturating add used by the
// collector's drop accounting.
// -----------------------------------------------------------------------------
package k12_pkg;

  localparam int NONCE_W = 64;
  localparam int DROP_W  = 16;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef logic [NONCE_W-1:0] nonce_t;

  // Adds b to a, clamping at DROP_MAX instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input int unsigned      b);
    int unsigned sum;
    sum = 32'(a) + b;
    if (sum > 32'(DROP_MAX)) begin
      return DROP_MAX;
    end
    return DROP_W'(sum);
  endfunction

endpackage : k12_pkg

// File: rtl/k12_nonce_fifo.sv
// -----------------------------------------------------------------------------
// k12_nonce_fifo
// First-word-fall-through synchronous FIFO for nonces.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear, overrides push and pop
//   push, push_data : write request (ignored when full)
//   pop         : consume head (ignored when empty)
//   pop_data    : head entry while not empty, else zero
//   empty, full : occupancy flags, derived from the pre-edge pointers
//   count       : number of stored entries (0..DEPTH)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module k12_nonce_fifo
  import k12_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  nonce_t      push_data,
  input  logic        pop,
  output nonce_t      pop_data,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count
);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  nonce_t      mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  // Fullness is judged on the pre-edge state: a simultaneous pop does not
  // make room for a push into a full FIFO.
  assign do_push = push && !full  && !flush;
  assign do_pop  = pop  && !empty && !flush;

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every output of a combinational block gets a default on entry so no
  // path leaves it unassigned (which would infer a latch); blocking '=' is
  // used here, while clocked blocks use '<=' only.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are live, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule : k12_nonce_fifo

// File: rtl/k12_result_collector.sv
// -----------------------------------------------------------------------------
// k12_result_collector
// Collects winning nonces from NCORE hash cores and queues them for the host.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of everything (issued with each job load)
//   store      : per-core one-cycle result strobe, bit i = core i
//   nonce      : core i nonce at [64*i +: 64], valid with store[i]
//   out_valid / out_nonce / out_ready : FWFT head of the result FIFO
//   count      : FIFO occupancy
//   overflow   : sticky, a nonce was dropped since reset/flush
//   dropped    : saturating count of dropped nonces
// Each core owns a one-entry holding register. Pending cores are merged into
// the FIFO round-robin, one per edge, starting at rr_ptr.
// -----------------------------------------------------------------------------
module k12_result_collector
  import k12_pkg::*;
#(
  parameter int NCORE = 4,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NCORE-1:0]           store,
  input  logic [NONCE_W*NCORE-1:0]   nonce,
  output logic                       out_valid,
  output logic [NONCE_W-1:0]         out_nonce,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          dropped
);

  localparam int RR_W = (NCORE > 1) ? $clog2(NCORE) : 1;

  logic [NCORE-1:0]  pending_q, pending_d;
  nonce_t            held_q [NCORE];
  nonce_t            held_d [NCORE];
  logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;
  logic              overflow_q, overflow_d;

  logic              grant_valid;
  logic [RR_W-1:0]   grant_idx;
  logic [RR_W:0]     cand_sum;
  int unsigned       drop_cnt;

  logic              fifo_empty;
  logic              fifo_full;
  nonce_t            fifo_head;

  // ---------------------------------------------------------------------------
  // Round-robin search: first pending core at or after rr_ptr, modulo NCORE.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    for (int k = 0; k < NCORE; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
      if (cand_sum >= (RR_W+1)'(NCORE)) begin
        cand_sum = cand_sum - (RR_W+1)'(NCORE);
      end
      if (!grant_valid && pending_q[cand_sum[RR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_sum[RR_W-1:0];
      end
    end
    if (fifo_full) begin
      grant_valid = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture, grant bookkeeping and drop accounting.
  // A granted core hands its old held value to the FIFO this edge, so a new
  // strobe on the same edge can refill the register instead of being dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    held_d    = held_q;
    rr_ptr_d  = rr_ptr_q;
    drop_cnt  = 0;

    if (grant_valid) begin
      pending_d[grant_idx] = 1'b0;
      rr_ptr_d = (grant_idx == RR_W'(NCORE-1)) ? '0 : RR_W'(grant_idx + 1'b1);
    end

    for (int i = 0; i < NCORE; i++) begin
      if (store[i]) begin
        if (!pending_q[i] || (grant_valid && grant_idx == RR_W'(i))) begin
          held_d[i]    = nonce[NONCE_W*i +: NONCE_W];
          pending_d[i] = 1'b1;
        end else begin
          drop_cnt = drop_cnt + 1;
        end
      end
    end

    dropped_d  = sat_add(dropped_q, drop_cnt);
    overflow_d = overflow_q | (drop_cnt != 0);

    // Flush wins over capture, grant and drop accounting alike.
    if (flush) begin
      pending_d  = '0;
      rr_ptr_d   = '0;
      dropped_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  // Held values are only meaningful while the matching pending bit is set.
  always_ff @(posedge clk) begin
    held_q <= held_d;
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  k12_nonce_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (grant_valid),
    .push_data (held_q[grant_idx]),
    .pop       (out_valid && out_ready),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

  assign out_valid = !fifo_empty;
  assign out_nonce = fifo_head;
  assign overflow  = overflow_q;
  assign dropped   = dropped_q;

endmodule : k12_result_collector

// File: tb/tb_k12_result_collector.sv
// -----------------------------------------------------------------------------
// tb_k12_result_collector
// Directed scenarios plus randomized traffic. A behavioural model advances one
// step per clock edge and pushes each nonce it expects to be queued onto
// exp_q; an independent monitor compares every presented head against exp_q
// and checks the status outputs against the model.
// -----------------------------------------------------------------------------
module tb_k12_result_collector;
  import k12_pkg::*;

  localparam int NCORE = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     flush = 1'b0;
  logic [NCORE-1:0]         store = '0;
  logic [NONCE_W*NCORE-1:0] nonce = '0;
  logic                     out_ready = 1'b0;
  logic                     out_valid;
  logic [NONCE_W-1:0]       out_nonce;
  logic [CW-1:0]            count;
  logic                     overflow;
  logic [DROP_W-1:0]        dropped;

  k12_result_collector #(
    .NCORE (NCORE),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .store     (store),
    .nonce     (nonce),
    .out_valid (out_valid),
    .out_nonce (out_nonce),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  bit     m_pend [NCORE];
  nonce_t m_held [NCORE];
  int     m_rr;
  int     m_count;
  int     m_drop;
  bit     m_ovf;
  nonce_t exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCORE; i++) m_pend[i] = 1'b0;
    m_rr    = 0;
    m_count = 0;
    m_drop  = 0;
    m_ovf   = 1'b0;
    exp_q.delete();
  endfunction

  // One clock edge of the collector's documented behaviour, using the inputs
  // that were presented to that edge.
  function automatic void model_step();
    bit old_pend [NCORE];
    bit do_pop;
    int g;
    if (flush) begin
      model_reset();
      return;
    end
    old_pend = m_pend;
    do_pop   = (m_count > 0) && out_ready;
    g        = -1;
    if (m_count < DEPTH) begin
      for (int k = 0; k < NCORE; k++) begin
        int c = (m_rr + k) % NCORE;
        if (g < 0 && old_pend[c]) g = c;
      end
    end
    if (g >= 0) begin
      exp_q.push_back(m_held[g]);
      m_pend[g] = 1'b0;
      m_rr      = (g + 1) % NCORE;
      m_count++;
    end
    for (int i = 0; i < NCORE; i++) begin
      if (store[i]) begin
        if (!old_pend[i] || i == g) begin
          m_held[i] = nonce[NONCE_W*i +: NONCE_W];
          m_pend[i] = 1'b1;
        end else begin
          if (m_drop < 65535) m_drop++;
          m_ovf = 1'b1;
        end
      end
    end
    if (do_pop) m_count--;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 64'(out_valid), 64'(m_count > 0));
      check("count", 64'(count), 64'(m_count));
      check("dropped", 64'(dropped), 64'(m_drop));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("head_unexpected", out_nonce, 64'hDEAD_0000_0000_DEAD);
        end else begin
          check("head", out_nonce, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_nonce", out_nonce, 64'h0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    store = '0;
    flush = 1'b0;
  endtask

  task automatic strobe(input int core, input nonce_t v);
    store[core] = 1'b1;
    nonce[NONCE_W*core +: NONCE_W] = v;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nonce_t order_a [4] = '{64'd10, 64'd11, 64'd12, 64'd13};
    nonce_t order_b [4] = '{64'd12, 64'd13, 64'd10, 64'd11};

    model_reset();
    #2;
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_count", 64'(count), 64'h0);
    check("rst_nonce", out_nonce, 64'h0);
    check("rst_dropped", 64'(dropped), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single result: two-edge latency, then popped.
    out_ready = 1'b1;
    strobe(2, 64'h42);
    tick();
    check("single_lat1_valid", 64'(out_valid), 64'h0);
    tick();
    check("single_valid", 64'(out_valid), 64'h1);
    check("single_nonce", out_nonce, 64'h42);
    check("single_count", 64'(count), 64'h1);
    tick();
    check("single_count_after_pop", 64'(count), 64'h0);
    tick();

    // Simultaneous strobes from rr_ptr = 0.
    do_flush();
    for (int i = 0; i < NCORE; i++) strobe(i, order_a[i]);
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      check("rr0_order", out_nonce, order_a[j]);
    end
    tick();

    // Move rr_ptr to 2 by granting core 1 alone, then repeat.
    strobe(1, 64'h1);
    repeat (3) tick();
    for (int i = 0; i < NCORE; i++) strobe(i, order_a[i]);
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      check("rr2_order", out_nonce, order_b[j]);
    end
    repeat (2) tick();

    // Full FIFO: 17 strobes fill 16 entries plus one pending, then a drop.
    do_flush();
    out_ready = 1'b0;
    for (int s = 0; s < 17; s++) begin
      strobe(0, 64'(100 + s));
      tick();
      tick();
    end
    check("full_count", 64'(count), 64'd16);
    check("full_no_drop", 64'(dropped), 64'h0);
    strobe(0, 64'd999);
    tick();
    check("full_dropped", 64'(dropped), 64'h1);
    check("full_overflow", 64'(overflow), 64'h1);
    out_ready = 1'b1;
    repeat (20) tick();
    check("full_drained", 64'(count), 64'h0);
    check("full_overflow_sticky", 64'(overflow), 64'h1);

    // Grant-and-refill on core 1.
    do_flush();
    out_ready = 1'b1;
    strobe(1, 64'hAAAA);
    tick();
    strobe(1, 64'hBEEF);
    tick();
    check("refill_first", out_nonce, 64'hAAAA);
    tick();
    check("refill_second", out_nonce, 64'hBEEF);
    check("refill_no_drop", 64'(dropped), 64'h0);
    repeat (2) tick();

    // Flush mid-operation with a same-cycle store.
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      strobe(s % NCORE, 64'(200 + s));
      tick();
      tick();
    end
    strobe(0, 64'hF0);
    strobe(3, 64'hF3);
    tick();
    check("flush_pre_count", 64'(count), 64'd5);
    flush = 1'b1;
    strobe(1, 64'hF1);
    tick();
    check("flush_count", 64'(count), 64'h0);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_dropped", 64'(dropped), 64'h0);
    check("flush_overflow", 64'(overflow), 64'h0);
    repeat (4) tick();
    check("flush_no_pending", 64'(out_valid), 64'h0);

    // Asynchronous reset between edges with three entries queued.
    for (int i = 0; i < 3; i++) strobe(i, 64'(300 + i));
    repeat (5) tick();
    check("areset_pre_count", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_valid", 64'(out_valid), 64'h0);
    check("areset_count", 64'(count), 64'h0);
    check("areset_nonce", out_nonce, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    strobe(3, 64'h55);
    tick();
    check("areset_lat1_valid", 64'(out_valid), 64'h0);
    tick();
    check("areset_lat2_nonce", out_nonce, 64'h55);
    tick();

    // Randomized traffic: first mostly-ready, then backpressured.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NCORE; i++) begin
        if (($urandom % 4) == 0) strobe(i, {$urandom, $urandom});
      end
      out_ready = (c < 300) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      flush     = (($urandom % 128) == 0);
      tick();
    end
    out_ready = 1'b1;
    repeat (40) tick();

    // Drop counter saturation: all cores strobe continuously with no consumer.
    do_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 16420; c++) begin
      for (int i = 0; i < NCORE; i++) strobe(i, 64'(c * NCORE + i));
      tick();
    end
    check("sat_dropped", 64'(dropped), 64'hFFFF);
    check("sat_overflow", 64'(overflow), 64'h1);
    out_ready = 1'b1;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_k12_result_collector
